// File: rtl/tl_pkg.sv
// tl_pkg: shared TileLink definitions used by the socket and the L2.
//   - opcode constants for the A and C channels
//   - is_data_opcode(): does this opcode carry a data burst on the given channel
//   - beats_of(): number of beats a message occupies on a DATA_W-wide bus
package tl_pkg;

  typedef logic [2:0] tl_opcode_t;
  typedef logic [3:0] tl_size_t;

  // A channel opcodes
  localparam tl_opcode_t A_PUT_FULL    = 3'd0;
  localparam tl_opcode_t A_PUT_PARTIAL = 3'd1;
  localparam tl_opcode_t A_ARITH       = 3'd2;
  localparam tl_opcode_t A_LOGICAL     = 3'd3;
  localparam tl_opcode_t A_GET         = 3'd4;
  localparam tl_opcode_t A_INTENT      = 3'd5;

  // C channel opcodes that carry data
  localparam tl_opcode_t C_PROBE_ACK_DATA = 3'd5;
  localparam tl_opcode_t C_RELEASE_DATA   = 3'd7;

  function automatic logic is_data_opcode(input tl_opcode_t op, input logic chan_c);
    if (chan_c)
      return (op == C_PROBE_ACK_DATA) || (op == C_RELEASE_DATA);
    else
      return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL) ||
             (op == A_ARITH)    || (op == A_LOGICAL);
  endfunction

  // Beats for one message. Sizes beyond max_size are clamped; messages that
  // fit inside a single bus word, and dataless messages, take one beat.
  function automatic int unsigned beats_of(input tl_size_t size, input tl_opcode_t opcode,
                                           input int unsigned data_w, input int unsigned max_size,
                                           input logic chan_c);
    int unsigned eff_size;
    int unsigned bytes;
    int unsigned bytes_per_beat;
    eff_size       = (32'(size) > max_size) ? max_size : 32'(size);
    bytes          = 32'd1 << eff_size;
    bytes_per_beat = data_w / 8;
    if (!is_data_opcode(opcode, chan_c) || (bytes <= bytes_per_beat))
      return 1;
    return bytes / bytes_per_beat;
  endfunction

endpackage

// File: rtl/tl_skid_buf.sv
// tl_skid_buf: 2-entry register slice with valid/ready on both sides.
//   in_valid/in_ready/in_data    : upstream (arbiter) side
//   out_valid/out_ready/out_data : downstream (manager) side
// in_ready depends only on occupancy, so there is no combinational path from
// out_ready to in_ready; two entries keep full throughput with that cut.
module tl_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] mem_reg [2];
  logic         wr_ptr_reg;
  logic         rd_ptr_reg;
  logic [1:0]   count_reg;
  logic         push;
  logic         pop;

  assign in_ready  = (count_reg != 2'd2);
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= in_data;
  end

endmodule

// File: rtl/tl_burst_arb.sv
// tl_burst_arb: N-to-1 TileLink A/C channel arbiter with burst lock.
//   cli_*   : per-client request channels, packed client-major
//   mgr_*   : single manager-side channel; mgr_source_o = {client ID, source}
//   grant_o : one-hot current grant (zero when nothing is granted)
// The burst length is derived from opcode/size of the first beat. The grant
// stays locked to that client until its last beat has been accepted.
// OUT_REG=1 puts a 2-entry slice on the manager side; beats are counted on
// the arbiter side of that slice.
module tl_burst_arb
  import tl_pkg::*;
#(
  parameter int N_CLIENTS  = 4,
  parameter int DATA_W     = 64,
  parameter int SOURCE_W   = 4,
  parameter int PAYLOAD_W  = 150,
  parameter int CHAN_C     = 0,
  parameter int ARB_MODE   = 0,
  parameter int OUT_REG    = 0,
  parameter int MAX_SIZE   = 6,
  parameter int CID_W      = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1,
  parameter int M_SOURCE_W = SOURCE_W + CID_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_CLIENTS-1:0]           cli_valid_i,
  output logic [N_CLIENTS-1:0]           cli_ready_o,
  input  logic [N_CLIENTS*3-1:0]         cli_opcode_i,
  input  logic [N_CLIENTS*4-1:0]         cli_size_i,
  input  logic [N_CLIENTS*SOURCE_W-1:0]  cli_source_i,
  input  logic [N_CLIENTS*PAYLOAD_W-1:0] cli_payload_i,
  output logic                           mgr_valid_o,
  input  logic                           mgr_ready_i,
  output logic [2:0]                     mgr_opcode_o,
  output logic [3:0]                     mgr_size_o,
  output logic [M_SOURCE_W-1:0]          mgr_source_o,
  output logic [PAYLOAD_W-1:0]           mgr_payload_o,
  output logic [N_CLIENTS-1:0]           grant_o
);

  localparam int MAX_BEATS = ((1 << MAX_SIZE) * 8) / DATA_W;
  localparam int CNT_W     = $clog2((MAX_BEATS > 1) ? MAX_BEATS : 1) + 1;
  localparam int PKT_W     = 3 + 4 + M_SOURCE_W + PAYLOAD_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [CID_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [CID_W-1:0] lock_reg, lock_next;
  logic [CNT_W-1:0] remain_reg, remain_next;

  logic [2:0]           op_arr   [N_CLIENTS];
  logic [3:0]           size_arr [N_CLIENTS];
  logic [SOURCE_W-1:0]  src_arr  [N_CLIENTS];
  logic [PAYLOAD_W-1:0] pl_arr   [N_CLIENTS];

  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_unpack
    assign op_arr[gi]   = cli_opcode_i[gi*3 +: 3];
    assign size_arr[gi] = cli_size_i[gi*4 +: 4];
    assign src_arr[gi]  = cli_source_i[gi*SOURCE_W +: SOURCE_W];
    assign pl_arr[gi]   = cli_payload_i[gi*PAYLOAD_W +: PAYLOAD_W];
  end

  // Winner selection. The first loop picks the lowest valid index overall;
  // in round-robin mode the second loop overrides it with the lowest valid
  // index at or above the pointer, if any (masked priority encoder).
  logic [CID_W-1:0] win_idx;
  logic             win_any;

  always_comb begin
    win_idx = '0;
    win_any = 1'b0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (cli_valid_i[i]) begin
        win_idx = CID_W'(i);
        win_any = 1'b1;
      end
    end
    if (ARB_MODE == 0) begin
      for (int i = N_CLIENTS - 1; i >= 0; i--) begin
        if (cli_valid_i[i] && (i >= int'(rr_ptr_reg))) win_idx = CID_W'(i);
      end
    end
  end

  // During a burst the grant is frozen on the latched client, valid or not.
  logic [CID_W-1:0] gnt_idx;
  logic             gnt_any;
  logic             int_ready;
  logic             arb_valid;
  logic             fire;

  assign gnt_idx   = (state_reg == BURST) ? lock_reg : win_idx;
  assign gnt_any   = (state_reg == BURST) || win_any;
  assign arb_valid = gnt_any && cli_valid_i[gnt_idx];
  assign fire      = arb_valid && int_ready;

  // Outputs are held at their idle values while reset is asserted.
  for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_grant
    assign grant_o[gi]     = rst_n && gnt_any && (gnt_idx == CID_W'(gi));
    assign cli_ready_o[gi] = grant_o[gi] && int_ready;
  end

  logic [2:0]            arb_opcode;
  logic [3:0]            arb_size;
  logic [M_SOURCE_W-1:0] arb_source;
  logic [PAYLOAD_W-1:0]  arb_payload;
  int unsigned           first_beats;

  assign arb_opcode  = op_arr[gnt_idx];
  assign arb_size    = size_arr[gnt_idx];
  assign arb_source  = {gnt_idx, src_arr[gnt_idx]};
  assign arb_payload = pl_arr[gnt_idx];
  // Only meaningful in IDLE, where the current beat is a first beat.
  assign first_beats = beats_of(arb_size, arb_opcode, DATA_W, MAX_SIZE, CHAN_C != 0);

  function automatic logic [CID_W-1:0] next_ptr(input logic [CID_W-1:0] idx);
    return (int'(idx) == N_CLIENTS - 1) ? '0 : idx + CID_W'(1);
  endfunction

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    lock_next   = lock_reg;
    remain_next = remain_reg;
    if (fire) begin
      if (state_reg == IDLE) begin
        if (first_beats > 1) begin
          state_next  = BURST;
          lock_next   = win_idx;
          remain_next = CNT_W'(first_beats - 1);
        end else begin
          rr_ptr_next = next_ptr(win_idx);
        end
      end else begin
        remain_next = remain_reg - CNT_W'(1);
        if (remain_reg == CNT_W'(1)) begin
          state_next  = IDLE;
          rr_ptr_next = next_ptr(lock_reg);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      lock_reg   <= '0;
      remain_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      lock_reg   <= lock_next;
      remain_reg <= remain_next;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic             skid_in_ready;
    logic             skid_out_valid;
    logic [PKT_W-1:0] skid_out_data;

    tl_skid_buf #(.W(PKT_W)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (arb_valid),
      .in_ready  (skid_in_ready),
      .in_data   ({arb_opcode, arb_size, arb_source, arb_payload}),
      .out_valid (skid_out_valid),
      .out_ready (mgr_ready_i),
      .out_data  (skid_out_data)
    );

    assign int_ready   = skid_in_ready;
    assign mgr_valid_o = rst_n && skid_out_valid;
    assign {mgr_opcode_o, mgr_size_o, mgr_source_o, mgr_payload_o} = skid_out_data;
  end else begin : g_out_comb
    assign int_ready     = mgr_ready_i;
    assign mgr_valid_o   = rst_n && arb_valid;
    assign mgr_opcode_o  = arb_opcode;
    assign mgr_size_o    = arb_size;
    assign mgr_source_o  = arb_source;
    assign mgr_payload_o = arb_payload;
  end

endmodule

// File: tb/tb_tl_burst_arb.sv
// tb_tl_burst_arb: two arbiter instances driven by the same client traffic.
//   dut a: defaults (A channel, DATA_W=64, round-robin, zero-latency)
//   dut b: C channel, DATA_W=128, fixed priority, registered output
// A transaction-level reference model predicts grants, readies and the
// manager-side beat stream (a queue stands in for the output slice).
module tb_tl_burst_arb;

  localparam int N   = 4;
  localparam int SW  = 4;
  localparam int PW  = 150;
  localparam int MSW = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    cli_valid   = '0;
  logic [N*3-1:0]  cli_opcode  = '0;
  logic [N*4-1:0]  cli_size    = '0;
  logic [N*SW-1:0] cli_source  = '0;
  logic [N*PW-1:0] cli_payload = '0;
  logic [1:0]      mgr_ready   = '0;

  logic [N-1:0]   c_rdy [2];
  logic           m_vld [2];
  logic [2:0]     m_op  [2];
  logic [3:0]     m_sz  [2];
  logic [MSW-1:0] m_src [2];
  logic [PW-1:0]  m_pl  [2];
  logic [N-1:0]   gnt   [2];

  tl_burst_arb u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .cli_valid_i(cli_valid), .cli_ready_o(c_rdy[0]),
    .cli_opcode_i(cli_opcode), .cli_size_i(cli_size),
    .cli_source_i(cli_source), .cli_payload_i(cli_payload),
    .mgr_valid_o(m_vld[0]), .mgr_ready_i(mgr_ready[0]),
    .mgr_opcode_o(m_op[0]), .mgr_size_o(m_sz[0]),
    .mgr_source_o(m_src[0]), .mgr_payload_o(m_pl[0]),
    .grant_o(gnt[0])
  );

  tl_burst_arb #(.DATA_W(128), .CHAN_C(1), .ARB_MODE(1), .OUT_REG(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .cli_valid_i(cli_valid), .cli_ready_o(c_rdy[1]),
    .cli_opcode_i(cli_opcode), .cli_size_i(cli_size),
    .cli_source_i(cli_source), .cli_payload_i(cli_payload),
    .mgr_valid_o(m_vld[1]), .mgr_ready_i(mgr_ready[1]),
    .mgr_opcode_o(m_op[1]), .mgr_size_o(m_sz[1]),
    .mgr_source_o(m_src[1]), .mgr_payload_o(m_pl[1]),
    .grant_o(gnt[1])
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [2:0]     op;
    logic [3:0]     sz;
    logic [MSW-1:0] src;
    logic [PW-1:0]  pl;
  } beat_t;

  // Reference state: owning client of an unfinished burst (-1 = none),
  // beats still owed by it, and the client to consider first next time.
  int    owner [2];
  int    left  [2];
  int    pref  [2];
  beat_t bq [$];
  bit    rst_q = 1'b1;

  function automatic int beats_ref(input int op, input int sz, input int dw, input int chc);
    int  bytes;
    bit  data;
    data = (chc != 0) ? (op == 5 || op == 7) : (op <= 3);
    if (!data) return 1;
    bytes = 1 << ((sz > 6) ? 6 : sz);
    return (bytes * 8 <= dw) ? 1 : (bytes * 8) / dw;
  endfunction

  function automatic int pick(input int k);
    int c;
    if (owner[k] >= 0) return owner[k];
    for (int j = 0; j < N; j++) begin
      c = (k == 1) ? j : (pref[k] + j) % N;
      if (cli_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_beat(input string p, input int k, input beat_t e);
    check_eq({p, "_opcode"},  256'(m_op[k]),  256'(e.op));
    check_eq({p, "_size"},    256'(m_sz[k]),  256'(e.sz));
    check_eq({p, "_source"},  256'(m_src[k]), 256'(e.src));
    check_eq({p, "_payload"}, 256'(m_pl[k]),  256'(e.pl));
  endtask

  task automatic model_cycle(input int k);
    int           w;
    int           b;
    bit           irdy;
    bit           av;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    beat_t        bt;
    string        p;
    p    = (k == 0) ? "a" : "b";
    w    = pick(k);
    irdy = (k == 0) ? mgr_ready[0] : (bq.size() < 2);
    eg   = (w >= 0) ? N'(1 << w) : '0;
    er   = irdy ? eg : '0;
    check_eq({p, "_grant"}, 256'(gnt[k]), 256'(eg));
    check_eq({p, "_ready"}, 256'(c_rdy[k]), 256'(er));
    av = (w >= 0) && cli_valid[w];
    bt = '0;
    if (w >= 0) begin
      bt.op  = cli_opcode[w*3 +: 3];
      bt.sz  = cli_size[w*4 +: 4];
      bt.src = {2'(w), cli_source[w*SW +: SW]};
      bt.pl  = cli_payload[w*PW +: PW];
    end
    if (k == 0) begin
      check_eq("a_valid", 256'(m_vld[0]), 256'(av));
      if (av) check_beat("a", 0, bt);
    end else begin
      check_eq("b_valid", 256'(m_vld[1]), 256'(bq.size() != 0));
      if (bq.size() != 0) begin
        check_beat("b", 1, bq[0]);
        if (mgr_ready[1]) void'(bq.pop_front());
      end
    end
    if (av && irdy) begin
      if (k == 1) bq.push_back(bt);
      if (owner[k] < 0) begin
        b = beats_ref(int'(bt.op), int'(bt.sz), (k == 1) ? 128 : 64, k);
        if (b > 1) begin
          owner[k] = w;
          left[k]  = b - 1;
        end else begin
          pref[k] = (w + 1) % N;
        end
      end else begin
        left[k]--;
        if (left[k] == 0) begin
          owner[k] = -1;
          pref[k]  = (w + 1) % N;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      left[k]  = 0;
      pref[k]  = 0;
    end
    bq.delete();
  endtask

  // Sample at the falling edge; inputs change 1 time unit after the rising edge.
  task automatic step_chk();
    @(negedge clk);
    if (!rst_n) begin
      if (rst_q) begin
        for (int k = 0; k < 2; k++) begin
          check_eq("rst_grant", 256'(gnt[k]), 256'(0));
          check_eq("rst_ready", 256'(c_rdy[k]), 256'(0));
          check_eq("rst_valid", 256'(m_vld[k]), 256'(0));
        end
      end
      model_reset();
    end else begin
      model_cycle(0);
      model_cycle(1);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    rst_q = !rst_n;
    #1;
  endtask

  task automatic set_cli(input int c, input bit v, input int op, input int sz);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    cli_valid[c]             = v;
    cli_opcode[c*3 +: 3]     = 3'(op);
    cli_size[c*4 +: 4]       = 4'(sz);
    cli_source[c*SW +: SW]   = 4'($urandom);
    cli_payload[c*PW +: PW]  = r[PW-1:0];
  endtask

  task automatic clear_all();
    for (int c = 0; c < N; c++) set_cli(c, 1'b0, 4, 0);
  endtask

  initial begin
    model_reset();
    clear_all();
    for (int c = 0; c < N; c++) set_cli(c, 1'b1, 4, 0);
    rst_n = 1'b0;
    repeat (3) begin step_chk(); advance(); end
    rst_n     = 1'b1;
    mgr_ready = 2'b11;

    // Round-robin fairness with single-beat Gets; b shows 1-cycle latency then 1 beat/cycle.
    for (int i = 0; i < 12; i++) begin
      for (int c = 0; c < N; c++) set_cli(c, 1'b1, 4, 0);
      step_chk();
      check_eq("rr_grant", 256'(gnt[0]), 256'(1 << (i % 4)));
      check_eq("b_stream_valid", 256'(m_vld[1]), 256'(i > 0));
      advance();
    end

    // Burst lock: client 1 PutFull size 6 (8 beats on a); client 0 joins later.
    clear_all();
    for (int i = 0; i < 9; i++) begin
      set_cli(1, 1'b1, 0, 6);
      if (i >= 1) set_cli(0, 1'b1, 4, 0);
      step_chk();
      if (i < 8) begin
        check_eq("lock_rdy0", 256'(c_rdy[0][0]), 256'(0));
        check_eq("lock_gnt", 256'(gnt[0]), 256'(4'b0010));
      end else begin
        check_eq("lock_release", 256'(gnt[0]), 256'(4'b0001));
      end
      advance();
    end

    // Size-derived length on b: ReleaseData size 6 at DATA_W=128 is 4 beats.
    clear_all();
    for (int i = 0; i < 5; i++) begin
      set_cli(1, 1'b1, 7, 6);
      if (i >= 1) set_cli(0, 1'b1, 4, 0);
      step_chk();
      if (i < 4) check_eq("b_len_gnt", 256'(gnt[1]), 256'(4'b0010));
      else       check_eq("b_len_release", 256'(gnt[1]), 256'(4'b0001));
      advance();
    end

    // Mid-burst valid drop on a: grant held, manager valid low for 3 cycles.
    clear_all();
    step_chk(); advance();
    for (int i = 0; i < 11; i++) begin
      set_cli(2, !(i >= 3 && i < 6), 0, 6);
      step_chk();
      if (i >= 3 && i < 6) begin
        check_eq("stall_gnt", 256'(gnt[0]), 256'(4'b0100));
        check_eq("stall_valid", 256'(m_vld[0]), 256'(0));
      end
      advance();
    end

    // Manager backpressure on b for 5 cycles: slice fills, nothing is lost.
    clear_all();
    for (int i = 0; i < 13; i++) begin
      mgr_ready[1] = (i >= 5);
      set_cli(0, 1'b1, 5, 6);
      set_cli(3, 1'b1, 4, 0);
      step_chk();
      if (i >= 2 && i < 5) check_eq("b_full_ready", 256'(c_rdy[1]), 256'(0));
      advance();
    end
    mgr_ready = 2'b11;

    // Reset at beat 3 of an 8-beat burst on a, then restart from client 0.
    clear_all();
    step_chk(); advance();
    for (int i = 0; i < 2; i++) begin
      set_cli(1, 1'b1, 0, 6);
      step_chk(); advance();
    end
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) set_cli(c, 1'b1, 0, 6);
    step_chk(); advance();
    step_chk(); advance();
    rst_n = 1'b1;
    for (int c = 0; c < N; c++) set_cli(c, 1'b1, 4, 0);
    step_chk();
    check_eq("rst_restart_gnt", 256'(gnt[0]), 256'(4'b0001));
    advance();

    // Randomized traffic with random manager backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++)
        set_cli(c, ($urandom_range(0, 99) < 60), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      mgr_ready[0] = ($urandom_range(0, 99) < 70);
      mgr_ready[1] = ($urandom_range(0, 99) < 70);
      rst_n        = ($urandom_range(0, 499) != 0);
      step_chk();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
